sync_filt_bus: RTL and testbench
================================

# sync_filt_bus

Parametrised multi-channel level synchronizer with glitch filtering and edge detection, living entirely in the receiving (clk_B) domain. Each of WIDTH independent single-bit signals arriving from a foreign clock domain passes through a STAGES-deep flop chain. A per-channel stability counter follows the chain, and an output only changes after FILT consecutive cycles of the new value. It replaces the fixed two-flop crossing for control lines that need configurable depth, debounce and one-cycle change pulses.

## Interface
- WIDTH, 4, number of independent channels (≥1)
- STAGES, 2, synchronizer flop depth per channel (≥2)
- FILT, 3, consecutive differing cycles required before Dout updates (≥1; 1 = no filtering)
- RST_VAL, 0 (WIDTH bits), reset value of Dout
- Parameter violations are elaboration errors.

Ports:
- clk_B  input  1  receiving-domain clock; single clock, all flops rising-edge
- rst_n  input  1  asynchronous, active-low reset
- Din  input  WIDTH  asynchronous inputs; each bit is independent, with no bus coherency
- Dout  output  WIDTH  synchronized, filtered level; registered
- rise  output  WIDTH  one-cycle pulse on Dout 0→1; registered (only with SYNC_EDGE_DET_EN)
- fall  output  WIDTH  one-cycle pulse on Dout 1→0; registered (only with SYNC_EDGE_DET_EN)

## Operation
- Per channel i, sync chain s[0..STAGES-1]:
  - s[0] <= Din[i]
  - s[k] <= s[k-1]
  - sq = s[STAGES-1]
- Filter counter cnt, width ceil(log2(FILT)), min 1:
  - sq == Dout[i]: cnt <= 0.
  - sq != Dout[i] and cnt == FILT-1: Dout[i] <= sq, cnt <= 0.
  - sq != Dout[i] otherwise: cnt <= cnt+1.
- Glitch handling: if sq returns to Dout[i] before FILT differing cycles, cnt clears and no output change occurs. Differing cycles must be consecutive.
- Edge outputs:
  - rise[i] is high exactly in the cycle Dout[i] first reads 1.
  - fall[i] is high exactly in the cycle Dout[i] first reads 0.
  - Otherwise both are 0; rise and fall are never high together on one channel.
- Channels share nothing except clock and reset. Simultaneous changes on several channels produce simultaneous, independent pulses.
- Reset (async assert, any time, including mid-count):
  - s = 0, cnt = 0, Dout = RST_VAL, rise = fall = 0.
  - Release is assumed synchronized externally to clk_B.
  - After release, a channel with Din ≠ RST_VAL updates Dout and pulses once after the normal latency.

## Timing
- Latency: Din stable before clk_B edge n → Dout updates at edge n+STAGES+FILT-1.
  - Defaults: 4 edges after capture, i.e. visible 4 cycles after first sampling.
- rise/fall assert on the same edge as the Dout update and deassert on the next edge.
- Minimum Din pulse passed: FILT clk_B cycles as seen at sq. Shorter pulses are dropped.
- No combinational path from Din to any output.

## Configuration
- SYNC_EDGE_DET_EN defined: rise/fall ports and their registers are present, behaving as above.
- SYNC_EDGE_DET_EN undefined: rise/fall ports and logic are absent. Dout behaviour and latency are identical.

## Structure
- Package sync_pkg:
  - CNT_W computation function (clog2 with minimum 1)
  - Default parameter constants: SYNC_STAGES_DEF = 2, SYNC_FILT_DEF = 3
- Sub-module sync_filt_ch:
  - One channel: chain, counter, Dout bit, edge bits.
  - Instantiated WIDTH times via generate.
  - Top level only fans out ports and checks parameters.

## Test plan
All scenarios use WIDTH=4, STAGES=2, FILT=3, RST_VAL=0, SYNC_EDGE_DET_EN defined.
1. **Reset with Din differing:** rst_n=0, Din=4'hF for 3 cycles → Dout=0, rise=fall=0 throughout. Release → Dout=4'hF on the 4th edge after the first sample; rise=4'hF for exactly one cycle.
2. **Glitch rejection:** Din[1] high for 2 clk_B cycles → Dout[1] stays 0, no pulses. Din[1] high for 3 cycles → Dout[1] high for 3 cycles, then low. rise[1] and fall[1] each pulse once, 3 cycles apart.
3. **Simultaneous channels:** Din 4'b0101 → 4'b1010 in one cycle → rise=4'b1010 and fall=4'b0101 in the same cycle; Dout=4'b1010 from then on.
4. **Reset mid-filter:** Din[2] 0→1, then rst_n asserted 3 edges later (cnt=1) → Dout[2]=0 and cnt=0 immediately, no rise pulse. After release with Din[2]=1 held → full latency again, one rise pulse.
5. **Async stress:** Din toggling 1 ns after each edge of a 14 ns clock, clk_B at 10 ns, FILT=1 → Dout never X, rise/fall strictly alternate per channel, no double pulse. Repeat with FILT=3 and verify zero Dout changes (pulses of 1–2 clk_B cycles).
6. **Macro off:** rebuild without SYNC_EDGE_DET_EN and rerun scenarios 1–3 → Dout waveforms bit-identical to the macro-on runs.

Source files
------------

// File: rtl/sync_pkg.sv
// Shared constants and helpers for the sync_filt_bus synchronizer family.
// Optional edge-detect outputs are controlled by the SYNC_EDGE_DET_EN macro.
`timescale 1ns/1ps
package sync_pkg;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned SYNC_FILT_DEF   = 3;

  // Stability counter width: ceil(log2(filt)), never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned filt);
    return (filt <= 2) ? 1 : $clog2(filt);
  endfunction

endpackage

// File: rtl/sync_filt_bus_if.sv
// Bus bundle for sync_filt_bus: raw inputs, filtered levels and optional edge pulses.
// rise/fall only exist when SYNC_EDGE_DET_EN is defined.
`timescale 1ns/1ps
interface sync_filt_bus_if #(
  parameter int unsigned WIDTH = 4
);

  logic [WIDTH-1:0] Din;
  logic [WIDTH-1:0] Dout;
`ifdef SYNC_EDGE_DET_EN
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  modport master (output Din, input Dout, input rise, input fall);
  modport slave  (input Din, output Dout, output rise, output fall);
`else
  modport master (output Din, input Dout);
  modport slave  (input Din, output Dout);
`endif

endinterface

// File: rtl/sync_filt_ch.sv
// One synchronizer channel: flop chain, debounce counter, output level and
// (with SYNC_EDGE_DET_EN) registered one-cycle rise/fall pulses.
`timescale 1ns/1ps
module sync_filt_ch
  import sync_pkg::*;
#(
  parameter int unsigned STAGES  = SYNC_STAGES_DEF,
  parameter int unsigned FILT    = SYNC_FILT_DEF,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk_B,
  input  logic rst_n,
  input  logic din,
  output logic dout
`ifdef SYNC_EDGE_DET_EN
  ,
  output logic rise,
  output logic fall
`endif
);

  localparam int unsigned    CNT_W   = cnt_w(FILT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT - 1);

  logic [STAGES-1:0] sync_q;
  logic              sq;
  logic [CNT_W-1:0]  cnt_q;
  logic              upd;

  assign sq  = sync_q[STAGES-1];
  // Output flips on this edge: new value has now been seen FILT cycles in a row.
  assign upd = (sq != dout) && (cnt_q == CNT_MAX);

  // Metastability chain; only sq is ever looked at.
  always_ff @(posedge clk_B or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
    end
  end

  // Debounce: count consecutive differing cycles, any agreeing cycle restarts.
  always_ff @(posedge clk_B or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      dout  <= RST_VAL;
    end else if (sq == dout) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_q <= '0;
      dout  <= sq;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

`ifdef SYNC_EDGE_DET_EN
  // Pulses are registered alongside dout so they line up with the level change.
  always_ff @(posedge clk_B or negedge rst_n) begin
    if (!rst_n) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= upd & sq;
      fall <= upd & ~sq;
    end
  end
`endif

endmodule

// File: rtl/sync_filt_bus.sv
// Multi-channel level synchronizer with glitch filter, receiving (clk_B) domain only.
// Define SYNC_EDGE_DET_EN to add registered rise/fall pulse outputs.
`timescale 1ns/1ps
module sync_filt_bus
  import sync_pkg::*;
#(
  parameter int unsigned      WIDTH   = 4,
  parameter int unsigned      STAGES  = SYNC_STAGES_DEF,
  parameter int unsigned      FILT    = SYNC_FILT_DEF,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic             clk_B,
  input logic             rst_n,
  sync_filt_bus_if.slave  bus
);

  if (WIDTH < 1) begin : g_bad_width
    $error("sync_filt_bus: WIDTH must be >= 1");
  end
  if (STAGES < 2) begin : g_bad_stages
    $error("sync_filt_bus: STAGES must be >= 2");
  end
  if (FILT < 1) begin : g_bad_filt
    $error("sync_filt_bus: FILT must be >= 1");
  end

  logic [WIDTH-1:0] dout;
`ifdef SYNC_EDGE_DET_EN
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  assign bus.rise = rise;
  assign bus.fall = fall;
`endif

  assign bus.Dout = dout;

  // Channels are fully independent; no coherency across bits.
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sync_filt_ch #(
      .STAGES  (STAGES),
      .FILT    (FILT),
      .RST_VAL (RST_VAL[i])
    ) u_ch (
      .clk_B (clk_B),
      .rst_n (rst_n),
      .din   (bus.Din[i]),
      .dout  (dout[i])
`ifdef SYNC_EDGE_DET_EN
      ,
      .rise  (rise[i]),
      .fall  (fall[i])
`endif
    );
  end

endmodule

// File: tb/tb_sync_filt_bus.sv
// Directed self-checking bench for sync_filt_bus (FILT=3 main instance plus a
// FILT=1 instance). Edge-pulse checks are active when SYNC_EDGE_DET_EN is defined.
`timescale 1ns/1ps
module tb_sync_filt_bus;

  logic clk_B = 1'b0;
  logic rst_n = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  sync_filt_bus_if #(.WIDTH(4)) bus ();
  sync_filt_bus_if #(.WIDTH(4)) bus_f1 ();

  sync_filt_bus #(
    .WIDTH   (4),
    .STAGES  (2),
    .FILT    (3),
    .RST_VAL (4'h0)
  ) u_dut (
    .clk_B (clk_B),
    .rst_n (rst_n),
    .bus   (bus)
  );

  sync_filt_bus #(
    .WIDTH   (4),
    .STAGES  (2),
    .FILT    (1),
    .RST_VAL (4'h0)
  ) u_dut_f1 (
    .clk_B (clk_B),
    .rst_n (rst_n),
    .bus   (bus_f1)
  );

  always #5 clk_B = ~clk_B;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_B);
    #1;
  endtask

  task automatic set_din(input logic [3:0] v);
    bus.Din    = v;
    bus_f1.Din = v;
  endtask

  // Advance one cycle, then check the FILT=3 instance.
  task automatic step(input string tag, input logic [3:0] d, input logic [3:0] r,
                      input logic [3:0] f);
    tick();
    check_eq({tag, ".dout"}, 32'(bus.Dout), 32'(d));
`ifdef SYNC_EDGE_DET_EN
    check_eq({tag, ".rise"}, 32'(bus.rise), 32'(r));
    check_eq({tag, ".fall"}, 32'(bus.fall), 32'(f));
`endif
  endtask

  logic [3:0] h0, h1, h2, prev, v;

  initial begin
    set_din(4'h0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst.dout", 32'(bus.Dout), 32'h0);
    check_eq("rst.dout_f1", 32'(bus_f1.Dout), 32'h0);

    // 1: reset held with Din differing, then release.
    set_din(4'hF);
    repeat (3) step("s1_hold", 4'h0, 4'h0, 4'h0);
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step("s1_rel", (k >= 5) ? 4'hF : 4'h0, (k == 5) ? 4'hF : 4'h0, 4'h0);
      check_eq("s1_rel.dout_f1", 32'(bus_f1.Dout), (k >= 3) ? 32'hF : 32'h0);
    end

    // 2: back to zero, then 2-cycle glitch dropped, 3-cycle pulse passed.
    set_din(4'h0);
    repeat (4) step("s2_clr", 4'hF, 4'h0, 4'h0);
    step("s2_clr", 4'h0, 4'h0, 4'hF);
    step("s2_clr", 4'h0, 4'h0, 4'h0);
    set_din(4'h2);
    repeat (2) step("s2_glitch", 4'h0, 4'h0, 4'h0);
    set_din(4'h0);
    repeat (6) step("s2_glitch", 4'h0, 4'h0, 4'h0);
    set_din(4'h2);
    repeat (3) step("s2_pass", 4'h0, 4'h0, 4'h0);
    set_din(4'h0);
    step("s2_pass", 4'h0, 4'h0, 4'h0);
    step("s2_pass", 4'h2, 4'h2, 4'h0);
    step("s2_pass", 4'h2, 4'h0, 4'h0);
    step("s2_pass", 4'h2, 4'h0, 4'h0);
    step("s2_pass", 4'h0, 4'h0, 4'h2);
    step("s2_pass", 4'h0, 4'h0, 4'h0);

    // 3: simultaneous opposite changes on all channels.
    set_din(4'h5);
    repeat (4) step("s3_set", 4'h0, 4'h0, 4'h0);
    step("s3_set", 4'h5, 4'h5, 4'h0);
    step("s3_set", 4'h5, 4'h0, 4'h0);
    set_din(4'hA);
    repeat (4) step("s3_swap", 4'h5, 4'h0, 4'h0);
    step("s3_swap", 4'hA, 4'hA, 4'h5);
    step("s3_swap", 4'hA, 4'h0, 4'h0);
    step("s3_swap", 4'hA, 4'h0, 4'h0);

    // 4: reset asserted while channel 2 is mid-count.
    set_din(4'hE);
    repeat (3) step("s4_cnt", 4'hA, 4'h0, 4'h0);
    rst_n = 1'b0;
    #1;
    check_eq("s4_async.dout", 32'(bus.Dout), 32'h0);
`ifdef SYNC_EDGE_DET_EN
    check_eq("s4_async.rise", 32'(bus.rise), 32'h0);
`endif
    repeat (2) step("s4_hold", 4'h0, 4'h0, 4'h0);
    rst_n = 1'b1;
    repeat (4) step("s4_rel", 4'h0, 4'h0, 4'h0);
    step("s4_rel", 4'hE, 4'hE, 4'h0);
    step("s4_rel", 4'hE, 4'h0, 4'h0);

    // 5: single-cycle toggling; FILT=3 holds, FILT=1 follows with 2-cycle chain delay.
    h0 = 4'hE;
    h1 = 4'hE;
    h2 = 4'hE;
    prev = 4'hE;
    for (int i = 0; i < 48; i++) begin
      if (i < 24) v = (i % 2 == 0) ? 4'h1 : 4'hE;
      else        v = 4'($urandom_range(0, 15));
      set_din(v);
      h2 = h1;
      h1 = h0;
      h0 = v;
      tick();
      if (i < 24) begin
        check_eq("s5_f3.dout", 32'(bus.Dout), 32'hE);
`ifdef SYNC_EDGE_DET_EN
        check_eq("s5_f3.rise", 32'(bus.rise), 32'h0);
        check_eq("s5_f3.fall", 32'(bus.fall), 32'h0);
`endif
      end
      check_eq("s5_f1.dout", 32'(bus_f1.Dout), 32'(h2));
`ifdef SYNC_EDGE_DET_EN
      check_eq("s5_f1.rise", 32'(bus_f1.rise), 32'(h2 & ~prev));
      check_eq("s5_f1.fall", 32'(bus_f1.fall), 32'(~h2 & prev));
`endif
      prev = h2;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
